// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW/saturation stall scoreboard and taken-branch redirect sequencer
module hazard_ctrl #(
    parameter int NREGS = 32,
    parameter int DBITS = 32,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_wr_reg,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wr_reg,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [DBITS-1:0] br_target,
    output logic             de_stall,
    output logic             de_issue,
    output logic             flush_de,
    output logic             redirect_valid,
    output logic [DBITS-1:0] redirect_pc,
    output logic [NREGS-1:0] busy_vec,
    output logic             sb_err
);

    typedef enum logic {RUN, REDIRECT} state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t                      state_q, state_d;
    logic [DBITS-1:0]            redirect_pc_q, redirect_pc_d;
    logic [NREGS-1:0][CNTW-1:0]  cnt_q, cnt_d;
    logic                        sb_err_q, sb_err_d;
    logic                        raw_rs1, raw_rs2, sat_rd;
    logic                        inc, dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
            sb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
            sb_err_q      <= sb_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        flush_de      = 1'b0;

        // AGEX holds a bubble during REDIRECT, so br_valid is not looked at there
        case (state_q)
            RUN: begin
                if (br_valid && br_taken) begin
                    flush_de      = 1'b1;
                    redirect_pc_d = br_target;
                    state_d       = REDIRECT;
                end
            end
            REDIRECT: begin
                flush_de = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase

        raw_rs1  = de_use_rs1 && (de_rs1 != 5'd0) && (cnt_q[de_rs1] != '0);
        raw_rs2  = de_use_rs2 && (de_rs2 != 5'd0) && (cnt_q[de_rs2] != '0);
        sat_rd   = de_wr_reg && (cnt_q[de_rd] == CNT_MAX);
        de_stall = de_valid && (raw_rs1 || raw_rs2 || sat_rd);
        de_issue = de_valid && !de_stall && !flush_de;

        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            inc = de_issue && de_wr_reg && (de_rd == 5'(i));
            dec = wb_valid && wb_wr_reg && (wb_rd == 5'(i));
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) sb_err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
        end
        cnt_d[0] = '0;

        busy_vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_vec[i] = (cnt_q[i] != '0);
        end

        redirect_valid = (state_q == REDIRECT);
        redirect_pc    = redirect_pc_q;
        sb_err         = sb_err_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven directed bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        de_valid, de_use_rs1, de_use_rs2, de_wr_reg;
    logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
    logic        wb_valid, wb_wr_reg, br_valid, br_taken;
    logic [31:0] br_target;
    logic        de_stall, de_issue, flush_de, redirect_valid, sb_err;
    logic [31:0] redirect_pc, busy_vec;

    int n_vec = 0;
    int n_err = 0;
    int cur_row = 0;

    hazard_ctrl #(.NREGS(32), .DBITS(32), .CNTW(2)) dut (
        .clk(clk), .reset(reset),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .de_rd(de_rd), .de_wr_reg(de_wr_reg),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wr_reg(wb_wr_reg),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .de_stall(de_stall), .de_issue(de_issue), .flush_de(flush_de),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy_vec(busy_vec), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        wv;
        logic [4:0]  wrd;
        logic        bv;
        logic        bt;
        logic [31:0] bta;
        logic        e_stall;
        logic        e_issue;
        logic        e_flush;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic dv, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic [4:0] rd, logic wr, logic wv, logic [4:0] wrd,
                               logic bv, logic bt, logic [31:0] bta,
                               logic es, logic ei, logic ef, logic erv, logic [31:0] erpc,
                               logic [31:0] ebusy, logic eerr);
        vec_t r;
        r.dv = dv; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd; r.wr = wr;
        r.wv = wv; r.wrd = wrd; r.bv = bv; r.bt = bt; r.bta = bta;
        r.e_stall = es; r.e_issue = ei; r.e_flush = ef; r.e_rv = erv; r.e_rpc = erpc;
        r.e_busy = ebusy; r.e_err = eerr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h, expected %h", name, cur_row, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        de_valid = r.dv; de_rs1 = r.rs1; de_use_rs1 = r.u1; de_rs2 = r.rs2; de_use_rs2 = r.u2;
        de_rd = r.rd; de_wr_reg = r.wr;
        wb_valid = r.wv; wb_rd = r.wrd; wb_wr_reg = r.wv;
        br_valid = r.bv; br_taken = r.bt; br_target = r.bta;
    endtask

    task automatic idle();
        drive(v(0,0,0,0,0,0,0, 0,0, 0,0,32'h0, 0,0,0,0,0,0,0));
    endtask

    task automatic check_row(input vec_t r);
        chk("de_stall", 32'(de_stall), 32'(r.e_stall));
        chk("de_issue", 32'(de_issue), 32'(r.e_issue));
        chk("flush_de", 32'(flush_de), 32'(r.e_flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(r.e_rv));
        if (r.e_rv) chk("redirect_pc", redirect_pc, r.e_rpc);
        chk("busy_vec", busy_vec, r.e_busy);
        chk("sb_err", 32'(sb_err), 32'(r.e_err));
    endtask

    localparam logic [31:0] B3 = 32'h8, B4 = 32'h10, B5 = 32'h20, B7 = 32'h80;

    initial begin
        //        dv rs1 u1 rs2 u2 rd wr  wv wrd  bv bt bta          st is fl rv rpc        busy err
        tbl.push_back(v(1, 0,0, 0,0, 5,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   0,  0)); // issue rd5
        tbl.push_back(v(1, 5,1, 0,0, 0,0, 0,0, 0,0,32'h0,      1,0,0,0,32'h0,   B5, 0)); // RAW on rs1
        tbl.push_back(v(1, 5,1, 0,0, 0,0, 1,5, 0,0,32'h0,      1,0,0,0,32'h0,   B5, 0)); // WB same cycle, no bypass
        tbl.push_back(v(1, 5,1, 0,0, 0,0, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   0,  0)); // stall cleared
        tbl.push_back(v(1, 0,0, 0,0, 0,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   0,  0)); // rd=0 untracked
        tbl.push_back(v(1, 0,1, 0,1, 3,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   0,  0)); // x0 reads, rd3 #1
        tbl.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   B3, 0)); // rd3 #2
        tbl.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   B3, 0)); // rd3 #3
        tbl.push_back(v(1, 0,0, 0,0, 3,1, 0,0, 0,0,32'h0,      1,0,0,0,32'h0,   B3, 0)); // saturated
        tbl.push_back(v(0, 0,0, 0,0, 3,1, 0,0, 0,0,32'h0,      0,0,0,0,32'h0,   B3, 0)); // no de_valid
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,3, 0,0,32'h0,      0,0,0,0,32'h0,   B3, 0));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,3, 0,0,32'h0,      0,0,0,0,32'h0,   B3, 0));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,3, 0,0,32'h0,      0,0,0,0,32'h0,   B3, 0)); // cnt3 back to 0
        tbl.push_back(v(1, 0,0, 0,0, 7,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   0,  0)); // cnt7 = 1
        tbl.push_back(v(1, 0,0, 0,0, 7,1, 1,7, 0,0,32'h0,      0,1,0,0,32'h0,   B7, 0)); // inc+dec: stays 1
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,7, 0,0,32'h0,      0,0,0,0,32'h0,   B7, 0)); // one WB drains it
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 0,0, 0,0,32'h0,      0,0,0,0,32'h0,   0,  0));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 1,9, 0,0,32'h0,      0,0,0,0,32'h0,   0,  0)); // underflow rd9
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 0,0, 0,0,32'h0,      0,0,0,0,32'h0,   0,  1)); // sb_err sticky
        tbl.push_back(v(1, 0,0, 0,0, 4,1, 0,0, 1,1,32'h100,    0,0,1,0,32'h0,   0,  1)); // taken branch
        tbl.push_back(v(1, 0,0, 0,0, 4,1, 0,0, 1,1,32'h200,    0,0,1,1,32'h100, 0,  1)); // REDIRECT, br ignored
        tbl.push_back(v(1, 0,0, 0,0, 4,1, 0,0, 0,0,32'h0,      0,1,0,0,32'h0,   0,  1)); // back in RUN
        tbl.push_back(v(1, 4,1, 0,0, 0,0, 0,0, 1,0,32'h300,    1,0,0,0,32'h0,   B4, 1)); // not taken
        tbl.push_back(v(1, 4,1, 0,0, 0,0, 0,0, 1,1,32'h300,    1,0,1,0,32'h0,   B4, 1)); // stall + flush
        tbl.push_back(v(1, 0,0, 0,0, 0,0, 0,0, 0,0,32'h0,      0,0,1,1,32'h300, B4, 1));
        tbl.push_back(v(1, 0,0, 4,1, 0,0, 0,0, 1,1,32'h400,    1,0,1,0,32'h0,   B4, 1)); // back-to-back
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 0,0, 0,0,32'h0,      0,0,1,1,32'h400, B4, 1));
        tbl.push_back(v(0, 0,0, 0,0, 0,0, 0,0, 0,0,32'h0,      0,0,0,0,32'h0,   B4, 1));

        // reset held 2 cycles under random inputs
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            de_valid = 1'($urandom); de_rs1 = 5'($urandom); de_rs2 = 5'($urandom);
            de_use_rs1 = 1'($urandom); de_use_rs2 = 1'($urandom);
            de_rd = 5'($urandom); de_wr_reg = 1'($urandom);
            wb_valid = 1'($urandom); wb_rd = 5'($urandom); wb_wr_reg = 1'($urandom);
            br_valid = 1'($urandom); br_taken = 1'($urandom); br_target = $urandom;
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        cur_row = -1;
        chk("reset busy_vec", busy_vec, 32'h0);
        chk("reset sb_err", 32'(sb_err), 32'h0);
        chk("reset redirect_valid", 32'(redirect_valid), 32'h0);
        chk("reset redirect_pc", redirect_pc, 32'h0);
        chk("reset de_stall", 32'(de_stall), 32'h0);
        chk("reset flush_de", 32'(flush_de), 32'h0);

        foreach (tbl[k]) begin
            @(negedge clk);
            cur_row = k;
            drive(tbl[k]);
            #1;
            check_row(tbl[k]);
        end

        // reset landing on the REDIRECT cycle aborts the redirect and clears everything
        cur_row = 100;
        @(negedge clk);
        drive(v(1, 0,0, 0,0, 6,1, 0,0, 1,1,32'h500, 0,0,0,0,0,0,0));
        #1;
        chk("pre-reset flush_de", 32'(flush_de), 32'h1);
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("pre-reset redirect_valid", 32'(redirect_valid), 32'h1);
        chk("pre-reset redirect_pc", redirect_pc, 32'h500);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset redirect_valid", 32'(redirect_valid), 32'h0);
        chk("post-reset flush_de", 32'(flush_de), 32'h0);
        chk("post-reset busy_vec", busy_vec, 32'h0);
        chk("post-reset sb_err", 32'(sb_err), 32'h0);
        @(negedge clk);
        drive(v(1, 0,0, 0,0, 6,1, 0,0, 0,0,32'h0, 0,0,0,0,0,0,0));
        #1;
        chk("post-reset de_issue", 32'(de_issue), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and redirect controller for the five-stage core. It keeps a per-register scoreboard of pending writes between DE issue and WB retire, and stalls DE on read-after-write hazards or scoreboard saturation. It also sequences taken-branch and jump redirects from AGEX: it squashes the wrong-path instructions in DE and drives the redirect PC to FE.

## Interface
- NREGS, 32, architectural register count; x0 is never tracked
- DBITS, 32, PC width
- CNTW, 2, per-register pending-write counter width; maximum count is 2^CNTW-1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- de_valid  in  1  DE holds a valid instruction
- de_rs1, de_rs2  in  5  DE source register indices
- de_use_rs1, de_use_rs2  in  1  DE instruction reads rs1 / rs2
- de_rd  in  5  DE destination register index
- de_wr_reg  in  1  DE instruction writes de_rd
- wb_valid  in  1  WB retiring an instruction this cycle
- wb_rd  in  5  WB destination register index
- wb_wr_reg  in  1  WB instruction writes wb_rd
- br_valid  in  1  AGEX holds a branch or jump (is_branch)
- br_taken  in  1  AGEX branch condition is true
- br_target  in  DBITS  AGEX computed target
- de_stall  out  1  hold DE and FE; insert a bubble into AGEX
- de_issue  out  1  DE instruction advances into AGEX this cycle
- flush_de  out  1  squash the DE contents
- redirect_valid  out  1  FE loads redirect_pc this cycle
- redirect_pc  out  DBITS  redirect target
- busy_vec  out  NREGS  bit i set when counter i is nonzero
- sb_err  out  1  sticky scoreboard underflow flag

## Operation
**Scoreboard**
- One CNTW-bit counter per register 1..NREGS-1. Entry 0 is constant 0.
- Increment when de_issue is high, de_wr_reg is high and de_rd != 0.
- Decrement when wb_valid is high, wb_wr_reg is high and wb_rd != 0.
- If both hit the same register in the same cycle, the counter is unchanged.
- If a decrement hits a counter at 0, the counter holds at 0 and sb_err is set. sb_err stays set until reset.

**Hazard stall (combinational)**
- de_stall = de_valid AND any of:
  - de_use_rs1 and rs1 != 0 and cnt[rs1] != 0
  - de_use_rs2 and rs2 != 0 and cnt[rs2] != 0
  - de_wr_reg and cnt[de_rd] == max
- There is no bypass from a same-cycle WB write. The stall uses the registered counter.
- de_issue = de_valid AND NOT de_stall AND NOT flush_de.
- A squashed or stalled instruction never touches the scoreboard.

**Redirect FSM (states RUN, REDIRECT)**
- RUN:
  - br_valid with br_taken: flush_de = 1 in the same cycle, br_target is captured, next state is REDIRECT.
  - br_valid with NOT br_taken: no action.
  - No branch: no action.
- REDIRECT:
  - redirect_valid = 1 and redirect_pc = captured target.
  - flush_de = 1, squashing the wrong-path instruction fetched during the resolve cycle.
  - br_valid is ignored, because AGEX holds a bubble.
  - Unconditionally returns to RUN.
- A taken branch therefore costs a 2-cycle penalty. Not-taken branches cost nothing.
- Both flush_de and de_stall may be asserted in the same cycle; flush takes priority and de_issue = 0.

## Timing
**Reset values**
- All counters 0; busy_vec = 0; sb_err = 0.
- State RUN; redirect_valid = 0; redirect_pc = 0.
- de_stall, flush_de and de_issue are then purely combinational from state and inputs.

**Registered vs. combinational**
- Counters, sb_err, state and redirect_pc update on the rising edge of clk.
- redirect_valid is a decode of state, so it is glitch-free.
- de_stall, de_issue and flush_de have zero latency from their inputs.
- A stall clears in the cycle after WB retires the producing write.

**Reset mid-operation**
- Reset in REDIRECT aborts the redirect: the next cycle is RUN with redirect_valid = 0 and all counters cleared.

**Back-to-back branches**
- A second br_valid arriving in the cycle after REDIRECT (state RUN) is handled normally.

## Test plan
- Reset: assert reset for 2 cycles, drive random inputs, then release.
  - Required: busy_vec = 0, sb_err = 0, redirect_valid = 0, de_stall = 0 with de_valid = 0.
- RAW hazard: issue rd = 5 with wr, then present rs1 = 5 with use_rs1.
  - Required: de_stall = 1 until wb_rd = 5 retires; de_stall = 0 in the following cycle; busy_vec[5] goes 1 then 0.
- x0 and saturation:
  - Issue rd = 0: busy_vec stays 0, and rs1 = 0 never stalls.
  - Issue rd = 3 three times with no WB: cnt = 3, and the fourth rd = 3 writer gets de_stall = 1.
- Simultaneous issue and WB on rd = 7 with cnt = 1: cnt stays 1. Underflow: WB rd = 9 at cnt 0 sets sb_err = 1, which stays set until reset.
- Taken branch with br_target = 0x0000_0100:
  - Cycle 0: flush_de = 1, de_issue = 0.
  - Cycle 1: redirect_valid = 1, redirect_pc = 0x100, flush_de = 1.
  - Cycle 2: both outputs 0.
  - A not-taken branch produces no flush and no redirect.
- Reset asserted in the REDIRECT cycle: the next cycle has redirect_valid = 0, state RUN, busy_vec = 0.
